// File: rtl/wb_initiator_bridge.sv
// Wishbone B3 classic initiator: turns one local command into one bus cycle
// and returns read data or a timeout status on a valid/ready response port.
module wb_initiator_bridge #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // A zero TIMEOUT disables the abort; the last-count compare is then unused.
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [15:0] TIMER_LAST = TIMEOUT_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_accept;
  logic        w_timeoutHit;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_rspDat;
  logic        r_rspErr;
  logic [15:0] r_timer;
  logic [15:0] r_txnCount;

  // Next-state and state-decoded outputs; handshakes depend only on the registered state.
  always_comb begin
    w_nextState  = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    wbm_cyc_o    = 1'b0;
    busy         = 1'b1;
    w_accept     = 1'b0;
    w_timeoutHit = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        w_accept  = cmd_valid;
        if (cmd_valid) w_nextState = BUS;
      end
      BUS: begin
        wbm_cyc_o    = 1'b1;
        w_timeoutHit = TIMEOUT_EN && !wbm_ack_i && (r_timer == TIMER_LAST);
        if (wbm_ack_i || w_timeoutHit) w_nextState = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Command capture, cycle timer, response capture and completed-cycle counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we       <= 1'b0;
      r_sel      <= 4'd0;
      r_adr      <= 32'd0;
      r_dat      <= 32'd0;
      r_rspDat   <= 32'd0;
      r_rspErr   <= 1'b0;
      r_timer    <= 16'd0;
      r_txnCount <= 16'd0;
    end else begin
      if (w_accept) begin
        r_we    <= cmd_we;
        r_sel   <= cmd_sel;
        r_adr   <= cmd_adr;
        r_dat   <= cmd_dat;
        r_timer <= 16'd0;
      end
      if (r_state == BUS) begin
        if (wbm_ack_i) begin
          r_rspDat   <= r_we ? 32'd0 : wbm_dat_i;
          r_rspErr   <= 1'b0;
          r_txnCount <= r_txnCount + 16'd1;
        end else begin
          r_timer <= r_timer + 16'd1;
          if (w_timeoutHit) begin
            r_rspDat <= 32'd0;
            r_rspErr <= 1'b1;
          end
        end
      end
    end
  end

  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign rsp_dat   = r_rspDat;
  assign rsp_err   = r_rspErr;
  assign txn_count = r_txnCount;

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// Directed testbench for wb_initiator_bridge with a short timeout of 8 cycles.
module tb_wb_initiator_bridge;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = 4'd0;
  logic [31:0] cmd_adr = 32'd0;
  logic [31:0] cmd_dat = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'd0;
  logic        wbm_ack_i = 1'b0;
  logic        busy;
  logic [15:0] txn_count;

  int checks = 0;
  int errors = 0;

  wb_initiator_bridge #(.TIMEOUT(8)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_sel  (cmd_sel),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .busy     (busy),
    .txn_count(txn_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Present one command for a single edge; the bridge must be idle beforehand.
  task automatic issueCmd(input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
    cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Hold ack low for waitStates bus cycles then raise it; returns how many cycles cyc was high.
  task automatic runBus(input int waitStates, input logic [31:0] rdData, output int cycHigh);
    cycHigh = 0;
    wbm_dat_i = rdData;
    while (wbm_cyc_o && cycHigh < 50) begin
      cycHigh++;
      wbm_ack_i = (waitStates >= 0) && (cycHigh == waitStates + 1);
      tick();
    end
    wbm_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    tick();
    tick();
    wb_rst_i = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 ||
        busy !== 1'b0 || txn_count !== 16'd0 || rsp_dat !== 32'd0 || rsp_err !== 1'b0 ||
        wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0 || wbm_sel_o !== 4'd0 || wbm_we_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got rdy=%b rv=%b cyc=%b stb=%b busy=%b txn=%h want rdy=1 rest=0",
               cmd_ready, rsp_valid, wbm_cyc_o, wbm_stb_o, busy, txn_count);
    end
  endtask

  task automatic test_write();
    int cycHigh;
    issueCmd(1'b1, 4'hF, 32'h3000_0004, 32'h1234_5678);
    checks++;
    if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_adr_o !== 32'h3000_0004 ||
        wbm_dat_o !== 32'h1234_5678 || wbm_sel_o !== 4'hF || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_bus got cyc=%b we=%b adr=%h dat=%h sel=%h want 1 1 30000004 12345678 f",
               wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
    end
    runBus(2, 32'hFFFF_0000, cycHigh);
    checks++;
    if (cycHigh !== 3) begin
      errors++;
      $display("[TB] FAIL write_cyc_len got %0d want 3", cycHigh);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'd0 || rsp_err !== 1'b0 || txn_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL write_rsp got rv=%b dat=%h err=%b txn=%0d want 1 0 0 1",
               rsp_valid, rsp_dat, rsp_err, txn_count);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_idle got rdy=%b rv=%b busy=%b want 1 0 0", cmd_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_read_latency();
    rsp_ready = 1'b1;
    issueCmd(1'b0, 4'h3, 32'h3000_0000, 32'h5555_5555);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hDEAD_BEEF;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || wbm_cyc_o !== 1'b0 ||
        cmd_ready !== 1'b0 || txn_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL read_rsp got rv=%b dat=%h err=%b cyc=%b rdy=%b txn=%0d want 1 deadbeef 0 0 0 2",
               rsp_valid, rsp_dat, rsp_err, wbm_cyc_o, cmd_ready, txn_count);
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_next_accept got rdy=%b rv=%b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_timeout();
    int cycHigh;
    issueCmd(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    runBus(-1, 32'hABCD_0123, cycHigh);
    checks++;
    if (cycHigh !== 8 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'd0 || txn_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL timeout_abort got cyc=%0d rv=%b err=%b dat=%h txn=%0d want 8 1 1 0 2",
               cycHigh, rsp_valid, rsp_err, rsp_dat, txn_count);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    issueCmd(1'b0, 4'hF, 32'h3000_0014, 32'h0);
    runBus(7, 32'hCAFE_0001, cycHigh);
    checks++;
    if (cycHigh !== 8 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'hCAFE_0001 || txn_count !== 16'd3) begin
      errors++;
      $display("[TB] FAIL timeout_last_ack got cyc=%0d rv=%b err=%b dat=%h txn=%0d want 8 1 0 cafe0001 3",
               cycHigh, rsp_valid, rsp_err, rsp_dat, txn_count);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cycHigh;
    issueCmd(1'b0, 4'h1, 32'h3000_0020, 32'h0);
    runBus(0, 32'h0BAD_F00D, cycHigh);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0];
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'h1111_1111 * i;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0BAD_F00D || rsp_err !== 1'b0 || cmd_ready !== 1'b0 ||
          wbm_cyc_o !== 1'b0 || txn_count !== 16'd4 || wbm_adr_o !== 32'h3000_0020) begin
        errors++;
        $display("[TB] FAIL hold_rsp[%0d] got rv=%b dat=%h rdy=%b cyc=%b txn=%0d adr=%h want 1 0badf00d 0 0 4 30000020",
                 i, rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o, txn_count, wbm_adr_o);
      end
    end
    cmd_valid = 1'b0;
    wbm_ack_i = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release got rdy=%b busy=%b rv=%b cyc=%b want 1 0 0 0",
               cmd_ready, busy, rsp_valid, wbm_cyc_o);
    end
  endtask

  task automatic test_reset_mid_bus();
    issueCmd(1'b1, 4'hF, 32'h3000_0030, 32'h7777_7777);
    tick();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 ||
        txn_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_bus got cyc=%b stb=%b rv=%b rdy=%b txn=%0d want 0 0 0 1 0",
               wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, txn_count);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || txn_count !== 16'd0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stray_ack[%0d] got rv=%b cyc=%b txn=%0d rdy=%b want 0 0 0 1",
                 i, rsp_valid, wbm_cyc_o, txn_count, cmd_ready);
      end
    end
    wbm_ack_i = 1'b0;
  endtask

  task automatic test_counter_wrap();
    force dut.r_txnCount = 16'hFFFF;
    tick();
    release dut.r_txnCount;
    tick();
    checks++;
    if (txn_count !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL wrap_preload got %h want ffff", txn_count);
    end
    rsp_ready = 1'b1;
    issueCmd(1'b0, 4'hF, 32'h3000_0040, 32'h0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0000_00A5;
    tick();
    wbm_ack_i = 1'b0;
    checks++;
    if (txn_count !== 16'h0000 || rsp_dat !== 32'h0000_00A5) begin
      errors++;
      $display("[TB] FAIL wrap_count got txn=%h dat=%h want 0000 000000a5", txn_count, rsp_dat);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_read_latency();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
